// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes instruction words, drives the ALU from a 16x32 register file and writes results back
module alu_sequencer #(
  parameter int unsigned MUL_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  input  logic        alu_cond_met,
  output logic [3:0]  flags_q,
  output logic        retire,
  output logic [15:0] retire_count,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, MULW} state_t;
  localparam logic [2:0] MUL_LOAD = 3'(MUL_EXTRA == 0 ? 0 : MUL_EXTRA - 1);
  state_t      r_state;
  logic [3:0]  r_op, r_cond, r_rd, r_rn, r_rm;
  logic        r_s;
  logic [4:0]  r_sr_bit;
  logic [2:0]  r_sr_cont, r_cnt;
  logic [15:0] r_imm;
  logic [31:0] r_rf [16];
  logic        w_movi, w_mul_wait, w_last, w_wr_reg, w_wr_flags;
  assign w_movi      = instr[31:28] == 4'b0110;
  assign w_mul_wait  = r_op == 4'b0010 && MUL_EXTRA > 0;
  assign w_last      = (r_state == EXEC && !w_mul_wait) || (r_state == MULW && r_cnt == 3'd0);
  assign w_wr_reg    = alu_cond_met && (r_op <= 4'b0111 || r_op == 4'b1101);
  assign w_wr_flags  = alu_cond_met && ((r_op <= 4'b0101 && r_s) || r_op == 4'b1011);
  assign instr_ready = r_state == IDLE;
  assign alu_in1     = r_rf[r_rn];
  assign alu_in2     = r_rf[r_rm];
  assign alu_opcode  = r_op;
  assign alu_cond    = r_cond;
  assign alu_s       = r_s;
  assign alu_sr_cont = r_sr_cont;
  assign alu_sr_bit  = r_sr_bit;
  assign alu_imm     = r_imm;
  assign dbg_data    = r_rf[dbg_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_cond       <= '0;
      r_s          <= 1'b0;
      r_rd         <= '0;
      r_rn         <= '0;
      r_rm         <= '0;
      r_sr_bit     <= '0;
      r_sr_cont    <= '0;
      r_imm        <= '0;
      r_cnt        <= '0;
      flags_q      <= '0;
      retire       <= 1'b0;
      retire_count <= '0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else begin
      retire <= w_last;
      if (w_last) begin
        retire_count <= retire_count + 16'd1;
        if (w_wr_reg) r_rf[r_rd] <= alu_out;
        if (w_wr_flags) flags_q <= alu_flags;
      end
      case (r_state)
        IDLE: if (instr_valid) begin
          r_op      <= instr[31:28];
          r_cond    <= instr[27:24];
          r_s       <= instr[23];
          r_rd      <= instr[19:16];
          r_rn      <= w_movi ? 4'd0 : instr[15:12];
          r_rm      <= w_movi ? 4'd0 : instr[11:8];
          r_sr_bit  <= w_movi ? 5'd0 : instr[7:3];
          r_sr_cont <= w_movi ? 3'd0 : instr[2:0];
          r_imm     <= w_movi ? instr[15:0] : 16'd0;
          r_state   <= EXEC;
        end
        EXEC: begin
          r_state <= w_mul_wait ? MULW : IDLE;
          r_cnt   <= MUL_LOAD;
        end
        MULW: begin
          r_state <= r_cnt == 3'd0 ? IDLE : MULW;
          r_cnt   <= r_cnt - 3'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed check of alu_sequencer against a register-file level model
module tb_alu_sequencer;
  localparam int MX = 3;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_in1, alu_in2, alu_out, dbg_data;
  logic [3:0]  alu_opcode, alu_cond, alu_flags, flags_q, dbg_addr;
  logic        alu_s, alu_cond_met, retire;
  logic [2:0]  alu_sr_cont;
  logic [4:0]  alu_sr_bit;
  logic [15:0] alu_imm, retire_count;
  logic        cur_met;
  logic [3:0]  cur_flags;
  logic [31:0] m_rf [16];
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  int n_vec = 0;
  int n_err = 0;
  alu_sequencer #(.MUL_EXTRA(MX)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s),
    .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm), .alu_out(alu_out),
    .alu_flags(alu_flags), .alu_cond_met(alu_cond_met), .flags_q(flags_q), .retire(retire),
    .retire_count(retire_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
    return op == 4'd0 ? a + b : op == 4'd1 ? a - b : op == 4'd2 ? a * b : op == 4'd6 ? {16'd0, imm} : a ^ b ^ 32'h5A5A_0000;
  endfunction
  always_comb begin
    alu_out      = alu_fn(alu_opcode, alu_in1, alu_in2, alu_imm);
    alu_flags    = cur_flags;
    alu_cond_met = cur_met;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] cond, input logic s, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm, input logic [4:0] sb, input logic [2:0] sc);
    return {op, cond, s, 3'b000, rd, rn, rm, sb, sc};
  endfunction
  function automatic logic [31:0] movi(input logic [3:0] rd, input logic [15:0] imm);
    return {4'b0110, 4'd0, 1'b0, 3'b000, rd, imm};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_flags = '0;
    m_cnt   = '0;
  endtask
  task automatic run_instr(input logic [31:0] w, input logic met, input logic [3:0] fl);
    logic [3:0] op, rd, rn, rm;
    logic [15:0] imm;
    logic [31:0] res;
    int k, lat;
    op  = w[31:28];
    rd  = w[19:16];
    rn  = op == 4'd6 ? 4'd0 : w[15:12];
    rm  = op == 4'd6 ? 4'd0 : w[11:8];
    imm = op == 4'd6 ? w[15:0] : 16'd0;
    res = alu_fn(op, m_rf[rn], m_rf[rm], imm);
    lat = op == 4'd2 ? 2 + MX : 2;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    cur_met     = met;
    cur_flags   = fl;
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("opcode", {28'd0, alu_opcode}, {28'd0, op});
    chk("cond", {28'd0, alu_cond}, {28'd0, w[27:24]});
    chk("s", {31'd0, alu_s}, {31'd0, w[23]});
    chk("in1", alu_in1, m_rf[rn]);
    chk("in2", alu_in2, m_rf[rm]);
    chk("imm", {16'd0, alu_imm}, {16'd0, imm});
    chk("sr_bit", {27'd0, alu_sr_bit}, op == 4'd6 ? 32'd0 : {27'd0, w[7:3]});
    chk("sr_cont", {29'd0, alu_sr_cont}, op == 4'd6 ? 32'd0 : {29'd0, w[2:0]});
    k = 1;
    while (!retire && k < 20) begin
      chk("ready_low", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("retire_lat", k, lat);
    if (met && (op <= 4'd7 || op == 4'd13)) m_rf[rd] = res;
    if (met && ((op <= 4'd5 && w[23]) || op == 4'd11)) m_flags = fl;
    m_cnt++;
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, m_rf[rd]);
    chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
    chk("retire_count", {16'd0, retire_count}, {16'd0, m_cnt});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    cur_met = 1'b1;
    cur_flags = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_count", {16'd0, retire_count}, 32'd0);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    run_instr(movi(4'd3, 16'hAAAA), 1'b1, 4'h0);
    run_instr(enc(4'b1011, 4'd0, 1'b0, 4'd0, 4'd3, 4'd3, 5'd0, 3'd0), 1'b1, 4'hA);
    instr = movi(4'd3, 16'h7777);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_ready", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    dbg_addr = 4'd3;
    #1;
    model_reset();
    chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_flags", {28'd0, flags_q}, 32'd0);
    chk("midrst_count", {16'd0, retire_count}, 32'd0);
    chk("midrst_r3", dbg_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_noretire", {31'd0, retire}, 32'd0);
    chk("midrst_r3_after", dbg_data, 32'd0);
    run_instr(movi(4'd1, 16'h1234), 1'b1, 4'h3);
    run_instr(movi(4'd2, 16'h0005), 1'b1, 4'h3);
    run_instr(enc(4'b0000, 4'd0, 1'b1, 4'd3, 4'd1, 4'd2, 5'd0, 3'd0), 1'b1, 4'h6);
    chk("add_r3", m_rf[3], 32'h1239);
    chk("add_dbg_r3", dbg_data, 32'h1239);
    run_instr(enc(4'b0010, 4'd0, 1'b0, 4'd4, 4'd1, 4'd2, 5'd0, 3'd0), 1'b1, 4'h1);
    chk("mul_r4", dbg_data, 32'h5B04);
    run_instr(enc(4'b1011, 4'd0, 1'b0, 4'd9, 4'd1, 4'd2, 5'd0, 3'd0), 1'b1, 4'h9);
    dbg_addr = 4'd9;
    #1;
    chk("cmp_no_reg", dbg_data, 32'd0);
    run_instr(enc(4'b0001, 4'd0, 1'b1, 4'd5, 4'd1, 4'd2, 5'd0, 3'd0), 1'b0, 4'hF);
    chk("sub_skip_r5", dbg_data, 32'd0);
    run_instr(enc(4'b1111, 4'd0, 1'b1, 4'd1, 4'd1, 4'd2, 5'd0, 3'd0), 1'b1, 4'h2);
    run_instr(enc(4'b1110, 4'd0, 1'b1, 4'd2, 4'd1, 4'd2, 5'd0, 3'd0), 1'b1, 4'h2);
    force dut.retire_count = 16'hFFFE;
    #1;
    release dut.retire_count;
    m_cnt = 16'hFFFE;
    run_instr(enc(4'b1111, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 3'd0), 1'b1, 4'h0);
    run_instr(enc(4'b1111, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 3'd0), 1'b1, 4'h0);
    chk("wrap_zero", {16'd0, retire_count}, 32'd0);
    for (int i = 0; i < 80; i++)
      run_instr($urandom, $urandom_range(0, 3) != 0, 4'($urandom));
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("final_rf", dbg_data, m_rf[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
